// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_pkg                                                       |
// | Brief    : Shared types and constants for the instruction fetch unit.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_fifo                                                      |
// | Brief    : Prefetch FIFO of {pc, instr} entries with flush; head zeroed    |
// |            when empty.                                                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int c_cw  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  fetch_entry_t    wr_data,
    output logic [c_cw-1:0] count,
    output logic            head_valid,
    output fetch_entry_t    head
);

    localparam int c_aw = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr;
    logic [c_aw-1:0] r_rd;
    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= r_wr + c_aw'(1);
            if (pop)  r_rd <= r_rd + c_aw'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count      = r_count;
    assign head_valid = (r_count != '0);
    assign head       = head_valid ? r_mem[r_rd] : '0;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                                |
// | Brief    : PC owner, imem req/ack initiator, prefetch FIFO and redirect.   |
// |            FETCH_ALIGN_CHECK_EN adds a sticky fetch_misaligned flag.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int              c_cw    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_req;
    logic [XLEN-1:0] r_addr;

    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic [c_cw-1:0] w_count;
    logic [c_cw-1:0] w_count_n;
    logic [XLEN-1:0] w_pc_n;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_halt;
    logic            w_halt_n;
    logic            w_head_valid;
    fetch_entry_t    w_entry;
    fetch_entry_t    w_head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_mis;

    assign w_redir_pc = redirect_pc;
    assign w_halt     = r_mis;
    assign w_halt_n   = redirect_valid ? (redirect_pc[1:0] != 2'b00) : r_mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_mis <= 1'b0;
        else       r_mis <= w_halt_n;
    end

    assign fetch_misaligned = r_mis;
`else
    localparam logic [XLEN-1:0] c_align_mask = ~(XLEN'(INSTR_BYTES - 1));

    assign w_redir_pc = redirect_pc & c_align_mask;
    assign w_halt     = 1'b0;
    assign w_halt_n   = 1'b0;
`endif

    // Data returned for a pre-redirect (DRAIN) or halted request is dropped.
    assign w_fire  = r_req && imem_ack;
    assign w_push  = w_fire && !redirect_valid && (r_state != DRAIN) && !w_halt;
    assign w_pop   = w_head_valid && if_ready && !redirect_valid;
    assign w_pc_n  = redirect_valid ? w_redir_pc
                   : (w_push ? r_pc + XLEN'(INSTR_BYTES) : r_pc);
    assign w_entry = '{pc: r_addr, instr: imem_rdata};

    always_comb begin
        w_count_n = w_count;
        if (redirect_valid) begin
            w_count_n = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_n = w_count + c_cw'(1);
                2'b01:   w_count_n = w_count - c_cw'(1);
                default: w_count_n = w_count;
            endcase
        end
    end

    // Issue decision uses next-cycle occupancy so a push never lands on a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
        end else begin
            r_pc <= w_pc_n;
            if (r_req && !imem_ack) begin
                r_state <= (redirect_valid || r_state == DRAIN) ? DRAIN : WAIT;
            end else begin
                r_state <= RUN;
                r_req   <= (w_count_n < c_depth) && !w_halt_n;
                r_addr  <= w_pc_n;
            end
        end
    end

    fetch_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .wr_data    (w_entry),
        .count      (w_count),
        .head_valid (w_head_valid),
        .head       (w_head)
    );

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign if_valid  = w_head_valid;
    assign if_instr  = w_head.instr;
    assign if_pc     = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_unit                                             |
// | Brief    : Directed self-checking bench for instr_fetch_unit.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    logic        ack_on;
    int          n_checks;
    int          n_errors;
    int          reqs;

    instr_fetch_unit #(
        .XLEN           (32),
        .RESET_PC       (32'h0000_0000),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    // Memory model: word content is a fixed scramble of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_ack   = imem_req && ack_on;
    assign imem_rdata = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one time unit after a posedge with reset released.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        ack_on         = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        step();
        check("rst_req",    {31'd0, imem_req}, 32'd0);
        check("rst_addr",   imem_addr,         32'd0);
        check("rst_valid",  {31'd0, if_valid}, 32'd0);
        check("rst_instr",  if_instr,          32'd0);
        check("rst_pc",     if_pc,             32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_mis",    {31'd0, fetch_misaligned}, 32'd0);
`endif

        // 1: zero-wait streaming
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t1_addr", imem_addr, 32'(4 * (i - 1)));
            if (i == 1) check("t1_first_valid", {31'd0, if_valid}, 32'd0);
            if (i >= 2) begin
                check("t1_valid", {31'd0, if_valid}, 32'd1);
                check("t1_pc",    if_pc,    32'(4 * (i - 2)));
                check("t1_instr", if_instr, mem_word(32'(4 * (i - 2))));
            end
        end

        // 2: decode stalled, FIFO fills to 4 and fetch stops
        if_ready = 1'b0;
        do_reset();
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (imem_req) reqs++;
        end
        check("t2_reqs",     32'(reqs),         32'd4);
        check("t2_req_idle", {31'd0, imem_req}, 32'd0);
        check("t2_head_pc",  if_pc,             32'd0);
        if_ready = 1'b1;
        step();
        check("t2_resume_req",  {31'd0, imem_req}, 32'd1);
        check("t2_resume_addr", imem_addr,         32'h10);
        check("t2_head_pc2",    if_pc,             32'h4);

        // 3: three wait cycles on address 0x8
        do_reset();
        step();
        step();
        step();
        check("t3_addr0", imem_addr, 32'h8);
        ack_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_req",  {31'd0, imem_req}, 32'd1);
            check("t3_hold_addr", imem_addr,         32'h8);
            if (i == 1) check("t3_empty", {31'd0, if_valid}, 32'd0);
        end
        ack_on = 1'b1;
        step();
        check("t3_pc",    if_pc,     32'h8);
        check("t3_instr", if_instr,  mem_word(32'h8));
        check("t3_next",  imem_addr, 32'hC);
        ack_on = 1'b0;
        step();
        check("t3_one_push", {31'd0, if_valid}, 32'd0);
        // Asynchronous reset while a request is outstanding
        reset = 1'b1;
        #1;
        check("t3_async_req",  {31'd0, imem_req}, 32'd0);
        check("t3_async_addr", imem_addr,         32'd0);
        ack_on = 1'b1;

        // 4: redirect while 0x8 pending, ack two cycles later
        do_reset();
        step();
        step();
        step();
        ack_on         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("t4_drain_addr",  imem_addr,         32'h8);
        check("t4_drain_valid", {31'd0, if_valid}, 32'd0);
        step();
        check("t4_drain_req",   {31'd0, imem_req}, 32'd1);
        ack_on = 1'b1;
        step();
        check("t4_discard",     {31'd0, if_valid}, 32'd0);
        check("t4_new_addr",    imem_addr,         32'h100);
        step();
        check("t4_new_pc",      if_pc,             32'h100);
        check("t4_new_instr",   if_instr,          mem_word(32'h100));

        // 5: redirect together with ack and pop
        do_reset();
        step();
        step();
        step();
        check("t5_head_before", if_pc, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("t5_flushed", {31'd0, if_valid}, 32'd0);
        check("t5_addr",    imem_addr,         32'h40);
        step();
        check("t5_pc",      if_pc,             32'h40);

        // PC wrap at the top of the address space
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        step();
        check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        check("wrap_p0", if_pc,     32'hFFFF_FFF8);
        step();
        check("wrap_a2", imem_addr, 32'h0);
        check("wrap_p1", if_pc,     32'hFFFF_FFFC);
        step();
        check("wrap_p2", if_pc,     32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
        // 6: misaligned redirect halts fetch; aligned redirect recovers
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        check("t6_mis_set",  {31'd0, fetch_misaligned}, 32'd1);
        check("t6_no_req",   {31'd0, imem_req},         32'd0);
        check("t6_flushed",  {31'd0, if_valid},         32'd0);
        step();
        step();
        check("t6_still_halt", {31'd0, imem_req},       32'd0);
        check("t6_sticky",   {31'd0, fetch_misaligned}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("t6_mis_clr",  {31'd0, fetch_misaligned}, 32'd0);
        check("t6_req",      {31'd0, imem_req},         32'd1);
        check("t6_addr",     imem_addr,                 32'h200);
`else
        // Misaligned redirect target is word-aligned when loaded into pc
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        redirect_valid = 1'b0;
        check("align_addr", imem_addr, 32'h100);
        step();
        check("align_pc",   if_pc,     32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
